// File: rtl/mania_renderer_if.sv
// Pixel request / colour response bundle for the mania lane renderer.
// The master drives pixel coordinates, frame timing and lane inputs; the slave returns colour.
interface mania_renderer_if #(
  parameter int LANES   = 4,
  parameter int TRACK_H = 480
);
  logic                     frame_start;
  logic                     pix_valid;
  logic [9:0]               x;
  logic [9:0]               y;
  logic [LANES-1:0]         keys;
  logic [LANES*TRACK_H-1:0] tracks;
  logic [11:0]              color;
  logic                     color_valid;

  modport master (
    output frame_start, pix_valid, x, y, keys, tracks,
    input  color, color_valid
  );

  modport slave (
    input  frame_start, pix_valid, x, y, keys, tracks,
    output color, color_valid
  );
endinterface

// File: rtl/mania_renderer.sv
// Two-stage pixel renderer for a vertical-lane rhythm game field.
// Stage 1 classifies the pixel into a region and lane; stage 2 turns that into RGB444.
module mania_renderer #(
  parameter int LANES        = 4,
  parameter int LANE_W       = 100,
  parameter int BORDER       = 5,
  parameter int X0           = 50,
  parameter int TRACK_H      = 480,
  parameter int JUDGE_Y      = 440,
  parameter int FLASH_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  mania_renderer_if.slave  io
);

  localparam int P         = LANE_W + BORDER;
  localparam int FIELD_END = X0 + LANES * P + BORDER - 1;
  localparam int LANE_IW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ROW_IW    = (TRACK_H > 1) ? $clog2(TRACK_H) : 1;
  localparam logic [7:0] FLASH_INIT = 8'(FLASH_FRAMES);

  typedef enum logic [2:0] {
    R_OUTSIDE,
    R_JUDGE,
    R_BORDER,
    R_PAD,
    R_NOTE,
    R_TRACK
  } region_e;

  // Frame snapshot and per-lane flash state
  logic [LANES-1:0]         keys_d, keys_q;
  logic [LANES*TRACK_H-1:0] tracks_d, tracks_q;
  logic [LANES-1:0][7:0]    flash_d, flash_q;

  // Stage 1
  logic                     s1_valid_d, s1_valid_q;
  region_e                  region_d, region_q;
  logic [LANE_IW-1:0]       lane_d, lane_q;
  logic [LANES-1:0]         keys_s1_d, keys_s1_q;
  logic [LANES-1:0]         flash_s1_d, flash_s1_q;

  // Stage 2
  logic [11:0]              color_d, color_q;
  logic                     color_valid_d, color_valid_q;

  logic [31:0]              xi, yi;
  logic                     in_field, on_border, note_bit;
  logic [TRACK_H-1:0]       lane_row;

  // NOTE: every signal gets a default first so no path through the block can infer a latch.
  always_comb begin
    keys_d   = keys_q;
    tracks_d = tracks_q;
    flash_d  = flash_q;
    if (io.frame_start) begin
      keys_d   = io.keys;
      tracks_d = io.tracks;
      for (int i = 0; i < LANES; i++) begin
        if (io.keys[i] && !keys_q[i])
          flash_d[i] = FLASH_INIT;
        else if (flash_q[i] != 8'd0)
          flash_d[i] = flash_q[i] - 8'd1;
      end
    end
  end

  // Stage-1-aligned copies keep a frame_start-cycle pixel on the old snapshot in stage 2.
  always_comb begin
    keys_s1_d = keys_q;
    for (int i = 0; i < LANES; i++)
      flash_s1_d[i] = (flash_q[i] != 8'd0);
  end

  always_comb begin
    xi        = 32'(io.x);
    yi        = 32'(io.y);
    in_field  = (xi >= 32'(X0)) && (xi <= 32'(FIELD_END)) && (yi < 32'(TRACK_H));
    on_border = 1'b0;
    lane_d    = '0;
    lane_row  = '0;
    for (int k = 0; k <= LANES; k++) begin
      if ((xi >= 32'(X0 + k * P)) && (xi <= 32'(X0 + k * P + BORDER - 1)))
        on_border = 1'b1;
    end
    for (int i = 0; i < LANES; i++) begin
      if ((xi >= 32'(X0 + BORDER + i * P)) && (xi <= 32'(X0 + (i + 1) * P - 1))) begin
        lane_d   = LANE_IW'(i);
        lane_row = tracks_q[i*TRACK_H +: TRACK_H];
      end
    end
    note_bit = lane_row[io.y[ROW_IW-1:0]];

    if (!in_field)
      region_d = R_OUTSIDE;
    else if ((yi >= 32'(JUDGE_Y)) && (yi <= 32'(JUDGE_Y + BORDER - 1)))
      region_d = R_JUDGE;
    else if (on_border)
      region_d = R_BORDER;
    else if (yi >= 32'(JUDGE_Y + BORDER))
      region_d = R_PAD;
    else if (note_bit && (yi < 32'(JUDGE_Y)))
      region_d = R_NOTE;
    else
      region_d = R_TRACK;

    s1_valid_d = io.pix_valid;
  end

  always_comb begin
    color_valid_d = s1_valid_q;
    color_d       = 12'h000;
    if (s1_valid_q) begin
      unique case (region_q)
        R_JUDGE, R_BORDER: color_d = 12'hFFF;
        R_NOTE:            color_d = 12'hACD;
        R_PAD:             color_d = flash_s1_q[lane_q] ? 12'hFF0 :
                                     keys_s1_q[lane_q]  ? 12'h777 : 12'h444;
        R_TRACK:           color_d = keys_s1_q[lane_q] ? 12'h333 : 12'h000;
        default:           color_d = 12'h000;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every flop samples the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q        <= '0;
      tracks_q      <= '0;
      flash_q       <= '0;
      s1_valid_q    <= 1'b0;
      region_q      <= R_OUTSIDE;
      lane_q        <= '0;
      keys_s1_q     <= '0;
      flash_s1_q    <= '0;
      color_q       <= 12'h000;
      color_valid_q <= 1'b0;
    end else begin
      keys_q        <= keys_d;
      tracks_q      <= tracks_d;
      flash_q       <= flash_d;
      s1_valid_q    <= s1_valid_d;
      region_q      <= region_d;
      lane_q        <= lane_d;
      keys_s1_q     <= keys_s1_d;
      flash_s1_q    <= flash_s1_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
    end
  end

  assign io.color       = color_q;
  assign io.color_valid = color_valid_q;

endmodule

// File: tb/tb_mania_renderer.sv
// Directed bench for mania_renderer: a default 4-lane instance and a 6-lane, 60-pixel instance.
// Expected colours are hand-derived from the lane geometry and flash rules.
module tb_mania_renderer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mania_renderer_if #(.LANES(4), .TRACK_H(480)) io_a ();
  mania_renderer_if #(.LANES(6), .TRACK_H(480)) io_b ();

  mania_renderer dut_a (
    .clk (clk),
    .rst (rst),
    .io  (io_a)
  );

  mania_renderer #(.LANES(6), .LANE_W(60)) dut_b (
    .clk (clk),
    .rst (rst),
    .io  (io_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic render_a(input logic [9:0] px, input logic [9:0] py,
                          output logic [11:0] c, output logic v);
    @(posedge clk); #1;
    io_a.pix_valid = 1'b1; io_a.x = px; io_a.y = py;
    @(posedge clk); #1;
    io_a.pix_valid = 1'b0;
    @(posedge clk); #1;
    c = io_a.color; v = io_a.color_valid;
  endtask

  task automatic render_b(input logic [9:0] px, input logic [9:0] py,
                          output logic [11:0] c, output logic v);
    @(posedge clk); #1;
    io_b.pix_valid = 1'b1; io_b.x = px; io_b.y = py;
    @(posedge clk); #1;
    io_b.pix_valid = 1'b0;
    @(posedge clk); #1;
    c = io_b.color; v = io_b.color_valid;
  endtask

  task automatic frame_a(input int n);
    repeat (n) begin
      @(posedge clk); #1; io_a.frame_start = 1'b1;
      @(posedge clk); #1; io_a.frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [11:0] c;
    logic v;
    rst = 1'b1;
    io_a.pix_valid = 1'b1; io_a.x = 10'd52; io_a.y = 10'd100;
    io_a.frame_start = 1'b1; io_a.keys = 4'b0001;
    io_b.pix_valid = 1'b1; io_b.x = 10'd50; io_b.y = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (io_a.color !== 12'h000 || io_a.color_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got color=%h valid=%b exp color=000 valid=0", io_a.color, io_a.color_valid);
    end
    checks++;
    if (io_b.color !== 12'h000 || io_b.color_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got color=%h valid=%b exp color=000 valid=0", io_b.color, io_b.color_valid);
    end
    rst = 1'b0;
    io_a.pix_valid = 1'b0; io_a.frame_start = 1'b0; io_a.keys = '0;
    io_b.pix_valid = 1'b0;
    // Flash counters and latched keys must be clear: pad shows idle grey.
    render_a(10'd60, 10'd460, c, v);
    checks++;
    if (c !== 12'h444 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_pad got color=%h valid=%b exp color=444 valid=1", c, v);
    end
  endtask

  task automatic test_geometry();
    int          xs [13] = '{52, 60, 475, 474, 49, 155, 160, 60, 60, 60, 60, 60, 1023};
    int          ys [13] = '{100, 100, 100, 100, 100, 100, 100, 440, 444, 445, 479, 480, 1023};
    logic [11:0] ex [13] = '{12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000,
                             12'hFFF, 12'hFFF, 12'h444, 12'h444, 12'h000, 12'h000};
    logic [11:0] c;
    logic v;
    io_a.keys = '0; io_a.tracks = '0;
    frame_a(1);
    for (int i = 0; i < 13; i++) begin
      render_a(10'(xs[i]), 10'(ys[i]), c, v);
      checks++;
      if (c !== ex[i] || v !== 1'b1) begin
        errors++;
        $display("FAIL geometry(%0d,%0d) got color=%h valid=%b exp color=%h valid=1", xs[i], ys[i], c, v, ex[i]);
      end
    end
  endtask

  task automatic test_note();
    int          xs [7] = '{170, 170, 60, 170, 170, 259, 260};
    int          ys [7] = '{200, 201, 200, 199, 460, 200, 200};
    logic [11:0] ex [7] = '{12'hACD, 12'h000, 12'h000, 12'h000, 12'h444, 12'hACD, 12'hFFF};
    logic [11:0] c;
    logic v;
    io_a.tracks = '0;
    io_a.tracks[1*480+200] = 1'b1;
    io_a.tracks[1*480+460] = 1'b1;
    frame_a(1);
    for (int i = 0; i < 7; i++) begin
      render_a(10'(xs[i]), 10'(ys[i]), c, v);
      checks++;
      if (c !== ex[i] || v !== 1'b1) begin
        errors++;
        $display("FAIL note(%0d,%0d) got color=%h valid=%b exp color=%h valid=1", xs[i], ys[i], c, v, ex[i]);
      end
    end
  endtask

  task automatic test_flash();
    // Step list: key level, frames to issue, pixel, expected colour.
    logic        ks [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int          fr [10] = '{1, 0, 0, 7, 1, 1, 4, 1, 8, 1};
    int          xs [10] = '{60, 60, 170, 60, 60, 60, 60, 60, 60, 60};
    int          ys [10] = '{460, 100, 460, 460, 460, 460, 460, 460, 460, 460};
    logic [11:0] ex [10] = '{12'hFF0, 12'h333, 12'h444, 12'hFF0, 12'h777, 12'h444,
                             12'hFF0, 12'hFF0, 12'hFF0, 12'h777};
    logic [11:0] c;
    logic v;
    for (int i = 0; i < 10; i++) begin
      io_a.keys = {3'b000, ks[i]};
      frame_a(fr[i]);
      render_a(10'(xs[i]), 10'(ys[i]), c, v);
      checks++;
      if (c !== ex[i] || v !== 1'b1) begin
        errors++;
        $display("FAIL flash step %0d (%0d,%0d) got color=%h valid=%b exp color=%h", i, xs[i], ys[i], c, v, ex[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    int          xs [5] = '{60, 170, 60, 60, 170};
    int          ys [5] = '{460, 200, 100, 460, 200};
    int          fr [5] = '{0, 0, 0, 1, 0};
    logic [11:0] ex [5] = '{12'h777, 12'hACD, 12'h333, 12'h444, 12'h000};
    logic [11:0] c;
    logic v;
    io_a.keys = '0;
    io_a.tracks = '0;
    for (int i = 0; i < 5; i++) begin
      frame_a(fr[i]);
      render_a(10'(xs[i]), 10'(ys[i]), c, v);
      checks++;
      if (c !== ex[i] || v !== 1'b1) begin
        errors++;
        $display("FAIL snapshot step %0d (%0d,%0d) got color=%h valid=%b exp color=%h", i, xs[i], ys[i], c, v, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          xs [3] = '{60, 170, 60};
    int          ys [3] = '{460, 200, 460};
    logic [11:0] ex [3] = '{12'h444, 12'hACD, 12'hFF0};
    io_a.keys = 4'b0001;
    io_a.tracks = '0;
    io_a.tracks[1*480+200] = 1'b1;
    @(posedge clk); #1;
    io_a.frame_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        io_a.pix_valid = 1'b1; io_a.x = 10'(xs[i]); io_a.y = 10'(ys[i]);
      end else begin
        io_a.pix_valid = 1'b0;
      end
      if (i >= 2) begin
        checks++;
        if (io_a.color !== ex[i-2] || io_a.color_valid !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back pixel %0d got color=%h valid=%b exp color=%h valid=1",
                   i - 2, io_a.color, io_a.color_valid, ex[i-2]);
        end
      end
      @(posedge clk); #1;
      io_a.frame_start = 1'b0;
    end
    checks++;
    if (io_a.color !== 12'h000 || io_a.color_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back drain got color=%h valid=%b exp color=000 valid=0", io_a.color, io_a.color_valid);
    end
  endtask

  task automatic test_lanes6();
    int          xs [5] = '{440, 444, 445, 439, 50};
    logic [11:0] ex [5] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF};
    logic [11:0] c;
    logic v;
    for (int i = 0; i < 5; i++) begin
      render_b(10'(xs[i]), 10'd100, c, v);
      checks++;
      if (c !== ex[i] || v !== 1'b1) begin
        errors++;
        $display("FAIL lanes6 x=%0d got color=%h valid=%b exp color=%h valid=1", xs[i], c, v, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic       exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [11:0] exp_c [4] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF};
    @(posedge clk); #1;
    io_a.pix_valid = 1'b1; io_a.x = 10'd52; io_a.y = 10'd100;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (io_a.color !== 12'hFFF || io_a.color_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_pre_reset got color=%h valid=%b exp color=FFF valid=1", io_a.color, io_a.color_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io_a.color !== exp_c[i] || io_a.color_valid !== exp_v[i]) begin
        errors++;
        $display("FAIL stream_post_reset cycle %0d got color=%h valid=%b exp color=%h valid=%b",
                 i, io_a.color, io_a.color_valid, exp_c[i], exp_v[i]);
      end
      @(posedge clk); #1;
    end
    io_a.pix_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io_a.frame_start = 1'b0; io_a.pix_valid = 1'b0; io_a.x = '0; io_a.y = '0;
    io_a.keys = '0; io_a.tracks = '0;
    io_b.frame_start = 1'b0; io_b.pix_valid = 1'b0; io_b.x = '0; io_b.y = '0;
    io_b.keys = '0; io_b.tracks = '0;
    test_reset();
    test_geometry();
    test_note();
    test_flash();
    test_snapshot();
    test_back_to_back();
    test_lanes6();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mania_renderer.md
MANIA_RENDERER -- requirements
Module: mania_renderer

Interface
REQ-001 Parameter LANES, default 4, number of note lanes (1..8).
REQ-002 Parameter LANE_W, default 100, interior pixel width of one lane.
REQ-003 Parameter BORDER, default 5, border and judge-bar thickness in pixels.
REQ-004 Parameter X0, default 50, x of the leftmost border's first pixel.
REQ-005 Parameter TRACK_H, default 480, rows per lane bitmap.
REQ-006 Parameter JUDGE_Y, default 440, first row of the judge bar.
REQ-007 Parameter FLASH_FRAMES, default 8, hit-flash duration in frames (1..255).
REQ-008 clk  in  1  pixel-pipeline clock; one clock only, all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-011 pix_valid  in  1  the x/y pair on this cycle is to be rendered.
REQ-012 x  in  10  pixel column.
REQ-013 y  in  10  pixel row.
REQ-014 keys  in  LANES  key level per lane, 1 = pressed.
REQ-015 tracks  in  LANES*TRACK_H  note bitmaps; bit i*TRACK_H+r is lane i, row r.
REQ-016 color  out  12  RGB444 pixel colour.
REQ-017 color_valid  out  1  color corresponds to a pix_valid input 2 cycles earlier.

Function
REQ-018 Geometry: pitch P = LANE_W+BORDER; vertical border k (k=0..LANES) SHALL cover x in [X0+k*P, X0+k*P+BORDER-1]; lane i interior SHALL cover x in [X0+BORDER+i*P, X0+(i+1)*P-1]; field SHALL be X0 .. X0+LANES*P+BORDER-1.
REQ-019 Region priority, highest first: OUTSIDE (x outside field or y>=TRACK_H), JUDGE (y in [JUDGE_Y, JUDGE_Y+BORDER-1]), BORDER, PAD (y>=JUDGE_Y+BORDER), NOTE (snapshot bit set, y<JUDGE_Y), TRACK.
REQ-020 Colours: OUTSIDE 000; JUDGE and BORDER FFF; NOTE ACD; PAD FF0 while lane flash counter nonzero, else 777 if key latched pressed, else 444; TRACK 333 if key latched pressed, else 000.
REQ-021 Pipeline: stage 1 SHALL register region and lane index; stage 2 SHALL register color; latency exactly 2 cycles; one pixel per cycle throughput, no stalls.
REQ-022 color_valid SHALL be pix_valid delayed 2 cycles; color SHALL be 000 whenever color_valid is 0.
REQ-023 Lane index SHALL be computed by a parallel comparator chain, no divider.
REQ-024 Frame snapshot: on frame_start, keys and tracks SHALL be latched; rendering SHALL use only latched values for the whole frame (no tearing).
REQ-025 Key edge: a lane's latched key going 0->1 between consecutive frame_start pulses SHALL count as a hit.
REQ-026 Flash counter per lane, 8 bits: on hit SHALL load FLASH_FRAMES; else on frame_start SHALL decrement if nonzero; SHALL saturate at 0.
REQ-027 Hit on a lane whose counter is nonzero SHALL reload FLASH_FRAMES (retrigger).
REQ-028 frame_start coinciding with pix_valid SHALL render that pixel with the newly latched values only from the following cycle's stage-1 sample onward; the pixel on the frame_start cycle uses the prior snapshot.
REQ-029 Inputs with x or y outside field while pix_valid=1 SHALL render 000 with color_valid=1.

Reset
REQ-030 During rst: color=000, color_valid=0, pipeline valid bits cleared, latched keys=0, latched tracks=0, all flash counters=0.
REQ-031 rst asserted mid-frame SHALL discard in-flight pixels; first valid output after release appears 2 cycles after the first pix_valid.
REQ-032 First frame_start after reset SHALL not treat a key already held as a hit unless previous latched value (0) differs — i.e. a held key counts as one hit.

Verification
REQ-033 Defaults, keys=0, tracks=0, frame_start, then x=52,y=100 -> color FFF at cycle+2; x=60,y=100 -> 000; x=475,y=100 -> 000.
REQ-034 tracks bit 1*480+200 set, frame_start, x=170,y=200 -> ACD; x=170,y=201 -> 000; x=60,y=200 -> 000.
REQ-035 keys=0001 before frame_start, x=60,y=460 -> FF0; after 8 further frame_start pulses with key held -> 777; key released then frame_start -> 444.
REQ-036 keys change mid-frame without frame_start -> rendered colours unchanged until next frame_start.
REQ-037 LANES=6, LANE_W=60 instance: border at x=50+6*65=440..444 -> FFF; x=445 -> 000.
REQ-038 Continuous pix_valid stream with rst pulsed one cycle -> color_valid low for 2 cycles after reset release, then one output per cycle.
